// File: rtl/vector_cache_pkg.sv
// Shared types for the vector cache tag path.
//   wr_buf_pld_t   : tag write buffer payload {index, tag, way_oh}
//   tag_ram_data_t : tag SRAM row data {vld, tag}
//   is_onehot      : way mask sanity check
package vector_cache_pkg;

  localparam int unsigned INDEX_W = 6;
  localparam int unsigned TAG_W   = 16;
  localparam int unsigned WAY_NUM = 4;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [WAY_NUM-1:0] way_oh;
  } wr_buf_pld_t;

  localparam int unsigned PLD_W = $bits(wr_buf_pld_t);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } tag_ram_data_t;

  // True when exactly one bit of the way mask is set.
  function automatic logic is_onehot(input logic [WAY_NUM-1:0] v);
    return (v != '0) && ((v & (v - WAY_NUM'(1))) == '0);
  endfunction

endpackage

// File: rtl/vec_cache_rr_arb.sv
// Round-robin arbiter with a registered priority pointer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : per-requester request
//   adv_en_i     : grant is consumed; pointer moves past the winner
//   grant_o      : one-hot grant (zero when no request), combinational
module vec_cache_rr_arb #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         adv_en_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  // Search requests starting at the pointer; first hit wins.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = PTR_W'((32'(ptr_q) + off) % N);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found) grant_o[gnt_idx] = 1'b1;
  end

  // Pointer moves only when the grant is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_en_i && found) ptr_d = PTR_W'((32'(gnt_idx) + 1) % N);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vec_cache_tag_wr_ctrl.sv
// Drains N_SRC tag write buffers into the single-port tag SRAM through a
// 1-entry staging register. Lookups have priority on the SRAM port until a
// staged write has waited STALL_MAX cycles, after which the write is forced.
// Optional macro: VEC_CACHE_TAG_WR_BYPASS_EN adds byp_* outputs so a lookup
// hitting the staged index can merge the pending tag instead of replaying.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   src_vld_i/src_pld_i  : per-source valid and flattened wr_buf_pld_t payload
//   src_rdy_o            : per-source ready, one-hot or zero
//   rd_req_vld_i/_rdy_o  : lookup request / SRAM port granted to lookup
//   lookup_index_i       : index of the in-flight lookup
//   wr_pend_hit_o        : staged write targets lookup_index_i
//   tag_ram_wr_*_o       : SRAM write strobe, row, way mask, {vld, tag}
//   err_onehot_o         : sticky, a staged way mask was not one-hot
//   byp_*_o (optional)   : staged tag/way for a hitting lookup
module vec_cache_tag_wr_ctrl
  import vector_cache_pkg::*;
#(
  parameter int unsigned N_SRC     = 2,
  parameter int unsigned STALL_MAX = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_SRC-1:0]       src_vld_i,
  input  logic [N_SRC*PLD_W-1:0] src_pld_i,
  output logic [N_SRC-1:0]       src_rdy_o,
  input  logic                   rd_req_vld_i,
  output logic                   rd_req_rdy_o,
  input  logic [INDEX_W-1:0]     lookup_index_i,
  output logic                   wr_pend_hit_o,
  output logic                   tag_ram_wr_en_o,
  output logic [INDEX_W-1:0]     tag_ram_wr_idx_o,
  output logic [WAY_NUM-1:0]     tag_ram_wr_mask_o,
  output logic [TAG_W:0]         tag_ram_wr_data_o,
  output logic                   err_onehot_o
`ifdef VEC_CACHE_TAG_WR_BYPASS_EN
  ,
  output logic                   byp_vld_o,
  output logic [WAY_NUM-1:0]     byp_way_oh_o,
  output logic [TAG_W-1:0]       byp_tag_o
`endif
);

  localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);

  logic             stg_vld_q, stg_vld_d;
  wr_buf_pld_t      stg_q, stg_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             err_q, err_d;

  logic             stg_live;
  logic             force_wr;
  logic             wr_fire;
  logic             can_accept;
  logic             stg_oh;
  logic [N_SRC-1:0] grant;
  wr_buf_pld_t      gnt_pld;
  tag_ram_data_t    wr_data;

  vec_cache_rr_arb #(.N(N_SRC)) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (src_vld_i),
    .adv_en_i (can_accept),
    .grant_o  (grant)
  );

  // Port arbitration between the staged write and lookups; a reset cycle
  // masks the stage so nothing is written or accepted.
  always_comb begin
    stg_live   = stg_vld_q & ~rst_i;
    stg_oh     = is_onehot(stg_q.way_oh);
    force_wr   = (stall_q == CNT_W'(STALL_MAX));
    wr_fire    = stg_live & (~rd_req_vld_i | force_wr);
    can_accept = ~rst_i & (~stg_vld_q | wr_fire);
  end

  // Payload of the granted source.
  always_comb begin
    gnt_pld = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant[i]) gnt_pld = wr_buf_pld_t'(src_pld_i[i*PLD_W +: PLD_W]);
    end
  end

  // Stage, stall counter and sticky error next-state.
  always_comb begin
    stg_vld_d = stg_vld_q;
    stg_d     = stg_q;
    stall_d   = stall_q;
    err_d     = err_q;
    if (wr_fire) begin
      stg_vld_d = 1'b0;
      stall_d   = '0;
      if (!stg_oh) err_d = 1'b1;
    end else if (stg_live && rd_req_vld_i) begin
      stall_d = stall_q + CNT_W'(1);
    end
    // Refill in the same cycle as the write keeps one write per cycle.
    if (|src_rdy_o) begin
      stg_vld_d = 1'b1;
      stg_d     = gnt_pld;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
      stall_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      stg_vld_q <= stg_vld_d;
      stg_q     <= stg_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
    end
  end

  // Outputs taken directly from the stage.
  always_comb begin
    wr_data.vld       = 1'b1;
    wr_data.tag       = stg_q.tag;
    src_rdy_o         = can_accept ? grant : '0;
    rd_req_rdy_o      = rd_req_vld_i & ~(stg_live & force_wr);
    wr_pend_hit_o     = stg_live & (stg_q.index == lookup_index_i);
    tag_ram_wr_en_o   = wr_fire & stg_oh;
    tag_ram_wr_idx_o  = stg_live ? stg_q.index  : '0;
    tag_ram_wr_mask_o = stg_live ? stg_q.way_oh : '0;
    tag_ram_wr_data_o = stg_live ? wr_data      : '0;
    err_onehot_o      = err_q & ~rst_i;
  end

`ifdef VEC_CACHE_TAG_WR_BYPASS_EN
  // Staged tag offered to a hitting lookup; bad way masks are never merged.
  always_comb begin
    byp_vld_o    = wr_pend_hit_o & stg_oh;
    byp_way_oh_o = stg_live ? stg_q.way_oh : '0;
    byp_tag_o    = stg_live ? stg_q.tag    : '0;
  end
`endif

endmodule
